// File: rtl/display_pkg.sv
// Shared display-path types and constants: BCD digit type, the add-3 threshold,
// the binary-to-BCD converter FSM states and a saturating power-of-ten helper.
package display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Saturates at all-ones so large digit counts still elaborate to a usable limit.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            if (r > 64'd1844674407370955161) begin
                r = '1;
            end else begin
                r = r * 64'd10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get 3 added before the shift
// so that the doubling carries correctly into the next decimal digit.
module bcd_add3
    import display_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADD3_THRESH) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential shift-add-3 binary-to-BCD converter for the seg7 display path.
// Reconverts on value change or start pulse; bcd/overflow update atomically with done.
module bin_to_bcd_serial
    import display_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      value,
    input  logic                  start,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  overflow,
    output logic                  busy,
    output logic                  done,
    output conv_state_t           fsm_state
);

    localparam int SW    = DIGITS * 4;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = WIDTH + 1;

    // Overflow is only reachable when 10**DIGITS fits below 2**WIDTH.
    localparam longint unsigned LIMIT        = pow10(DIGITS);
    localparam bit              OVF_POSSIBLE = (WIDTH >= 64) || (LIMIT < (64'd1 << WIDTH));
    localparam logic [CMP_W-1:0] OVF_LIMIT   = OVF_POSSIBLE ? CMP_W'(LIMIT) : '1;

    conv_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [SW-1:0]      scratch_q, scratch_d;
    logic [WIDTH-1:0]   last_value_q, last_value_d;
    logic               pending_q, pending_d;
    logic [SW-1:0]      bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SW-1:0]          corrected;
    logic [SW+WIDTH-1:0]    shifted;
    logic                   request;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[d*4 +: 4]),
            .digit_o (corrected[d*4 +: 4])
        );
    end

    // Top bit of the scratch falls off: only the low DIGITS decimal digits are kept.
    assign shifted = {corrected[SW-2:0], shreg_q, 1'b0};
    assign request = pending_q | start | (value != last_value_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        scratch_d    = scratch_q;
        last_value_d = last_value_q;
        pending_d    = pending_q;
        bcd_d        = bcd_q;
        overflow_d   = overflow_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    shreg_d      = value;
                    last_value_d = value;
                    scratch_d    = '0;
                    cnt_d        = '0;
                    pending_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (start) begin
                    pending_d = 1'b1;
                end
                scratch_d = shifted[SW+WIDTH-1:WIDTH];
                shreg_d   = shifted[WIDTH-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                // Results land in the output registers so they are valid during COMMIT.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    bcd_d      = shifted[SW+WIDTH-1:WIDTH];
                    overflow_d = OVF_POSSIBLE && ({1'b0, last_value_q} >= OVF_LIMIT);
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (start) begin
                    pending_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            scratch_q    <= '0;
            last_value_q <= '0;
            pending_q    <= 1'b1;
            bcd_q        <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            scratch_q    <= scratch_d;
            last_value_q <= last_value_d;
            pending_q    <= pending_d;
            bcd_q        <= bcd_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bcd       = bcd_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Directed bench for bin_to_bcd_serial: a 4-bit/2-digit instance plus two 8-bit
// instances (3 and 2 digits) sharing clock and reset.
module tb_bin_to_bcd_serial;
    import display_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [3:0]  value;
    logic        start;
    logic [7:0]  bcd;
    logic        overflow, busy, done;
    conv_state_t fsm_state;

    logic [7:0]  v_w3, v_w2;
    logic        s_w3, s_w2;
    logic [11:0] bcd_w3;
    logic [7:0]  bcd_w2;
    logic        ovf_w3, ovf_w2, busy_w3, busy_w2, done_w3, done_w2;
    conv_state_t st_w3, st_w2;

    int n_vec = 0;
    int n_err = 0;

    bin_to_bcd_serial #(.WIDTH(4), .DIGITS(2)) u_dut (
        .clock(clock), .reset_n(reset_n), .value(value), .start(start),
        .bcd(bcd), .overflow(overflow), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    bin_to_bcd_serial #(.WIDTH(8), .DIGITS(3)) u_w3 (
        .clock(clock), .reset_n(reset_n), .value(v_w3), .start(s_w3),
        .bcd(bcd_w3), .overflow(ovf_w3), .busy(busy_w3), .done(done_w3), .fsm_state(st_w3)
    );

    bin_to_bcd_serial #(.WIDTH(8), .DIGITS(2)) u_w2 (
        .clock(clock), .reset_n(reset_n), .value(v_w2), .start(s_w2),
        .bcd(bcd_w2), .overflow(ovf_w2), .busy(busy_w2), .done(done_w2), .fsm_state(st_w2)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        value   = 4'd13;
        start   = 1'b0;
        v_w3    = 8'd255;
        v_w2    = 8'd150;
        s_w3    = 1'b0;
        s_w2    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_vec++; if (bcd !== 8'h00) begin n_err++; $display("FAIL reset_bcd: got %h want 00", bcd); end
        n_vec++; if (overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: ovf/busy/done=%b%b%b want 000", overflow, busy, done);
        end
        n_vec++; if (fsm_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", fsm_state, ST_IDLE); end
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy: got %b want 1", busy); end
            end
            n_vec++; if (done !== (i == 5)) begin n_err++; $display("FAIL first_done cycle %0d: got %b want %b", i + 1, done, i == 5); end
        end
        n_vec++; if (bcd !== 8'h13 || overflow !== 1'b0) begin
            n_err++; $display("FAIL first_result: bcd=%h ovf=%b want 13/0", bcd, overflow);
        end
    endtask

    task automatic test_value_change();
        step();
        value = 4'd7;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 1) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL chg_busy: got %b want 1", busy); end
            end
            n_vec++; if (done !== (i == 5)) begin n_err++; $display("FAIL chg_done step %0d: got %b want %b", i, done, i == 5); end
            n_vec++; if (bcd !== ((i == 5) ? 8'h07 : 8'h13)) begin
                n_err++; $display("FAIL chg_bcd step %0d: got %h want %h", i, bcd, (i == 5) ? 8'h07 : 8'h13);
            end
        end
        step();
        n_vec++; if (done !== 1'b0 || bcd !== 8'h07) begin
            n_err++; $display("FAIL chg_hold: done=%b bcd=%h want 0/07", done, bcd);
        end
    endtask

    task automatic test_wide();
        int d3, d2;
        n_vec++; if (bcd_w3 !== 12'h255 || ovf_w3 !== 1'b0) begin
            n_err++; $display("FAIL w3_255: bcd=%h ovf=%b want 255/0", bcd_w3, ovf_w3);
        end
        n_vec++; if (bcd_w2 !== 8'h50 || ovf_w2 !== 1'b1) begin
            n_err++; $display("FAIL w2_150: bcd=%h ovf=%b want 50/1", bcd_w2, ovf_w2);
        end
        v_w3 = 8'd100;
        v_w2 = 8'd99;
        d3 = 0; d2 = 0;
        for (int i = 0; i < 14; i++) begin step(); d3 += int'(done_w3); d2 += int'(done_w2); end
        n_vec++; if (d3 != 1 || bcd_w3 !== 12'h100 || ovf_w3 !== 1'b0) begin
            n_err++; $display("FAIL w3_100: dones=%0d bcd=%h ovf=%b want 1/100/0", d3, bcd_w3, ovf_w3);
        end
        n_vec++; if (d2 != 1 || bcd_w2 !== 8'h99 || ovf_w2 !== 1'b0) begin
            n_err++; $display("FAIL w2_99: dones=%0d bcd=%h ovf=%b want 1/99/0", d2, bcd_w2, ovf_w2);
        end
        v_w2 = 8'd100;
        d2 = 0;
        for (int i = 0; i < 14; i++) begin step(); d2 += int'(done_w2); end
        n_vec++; if (d2 != 1 || bcd_w2 !== 8'h00 || ovf_w2 !== 1'b1) begin
            n_err++; $display("FAIL w2_100: dones=%0d bcd=%h ovf=%b want 1/00/1", d2, bcd_w2, ovf_w2);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] vals [4];
        logic [7:0] exps [4];
        bit got;
        vals = '{4'd15, 4'd0, 4'd10, 4'd9};
        exps = '{8'h15, 8'h00, 8'h10, 8'h09};
        for (int v = 0; v < 4; v++) begin
            value = vals[v];
            got = 1'b0;
            for (int k = 0; k < 12 && !got; k++) begin
                step();
                if (done) got = 1'b1;
            end
            n_vec++; if (!got || bcd !== exps[v] || overflow !== 1'b0) begin
                n_err++; $display("FAIL bound_%0d: done_seen=%b bcd=%h ovf=%b want 1/%h/0", vals[v], got, bcd, overflow, exps[v]);
            end
        end
    endtask

    task automatic test_midflight();
        int n_done;
        logic [7:0] seen [2];
        seen = '{8'hxx, 8'hxx};
        n_done = 0;
        value = 4'd5;
        step();
        step();
        n_vec++; if (busy !== 1'b1 || fsm_state !== ST_SHIFT) begin
            n_err++; $display("FAIL mid_busy: busy=%b state=%0d want 1/%0d", busy, fsm_state, ST_SHIFT);
        end
        step();
        value = 4'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done) begin
                if (n_done < 2) seen[n_done] = bcd;
                n_done++;
            end
        end
        n_vec++; if (n_done != 2) begin n_err++; $display("FAIL mid_count: got %0d done pulses want 2", n_done); end
        n_vec++; if (seen[0] !== 8'h05) begin n_err++; $display("FAIL mid_first: got %h want 05", seen[0]); end
        n_vec++; if (seen[1] !== 8'h09) begin n_err++; $display("FAIL mid_second: got %h want 09", seen[1]); end
    endtask

    task automatic test_reset_midflight();
        value = 4'd11;
        step();
        step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        reset_n = 1'b0;
        #1;
        n_vec++; if (bcd !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== ST_IDLE) begin
            n_err++; $display("FAIL rstmid_clear: bcd=%h busy=%b done=%b state=%0d want 00/0/0/0", bcd, busy, done, fsm_state);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_nodone: got %b want 0", done); end
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_vec++; if (done !== (i == 5)) begin n_err++; $display("FAIL rstmid_done cycle %0d: got %b want %b", i + 1, done, i == 5); end
        end
        n_vec++; if (bcd !== 8'h11) begin n_err++; $display("FAIL rstmid_result: got %h want 11", bcd); end
    endtask

    task automatic test_start_static();
        int n_done, n_busy;
        bit got;
        value = 4'd3;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            step();
            if (done) got = 1'b1;
        end
        n_vec++; if (!got || bcd !== 8'h03) begin n_err++; $display("FAIL start_pre: done_seen=%b bcd=%h want 1/03", got, bcd); end
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin step(); n_done += int'(done); end
        n_vec++; if (n_done != 1 || bcd !== 8'h03) begin
            n_err++; $display("FAIL start_same: dones=%0d bcd=%h want 1/03", n_done, bcd);
        end
        value = 4'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin step(); n_done += int'(done); end
        n_vec++; if (n_done != 1 || bcd !== 8'h04) begin
            n_err++; $display("FAIL start_and_change: dones=%0d bcd=%h want 1/04", n_done, bcd);
        end
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 100; i++) begin step(); n_done += int'(done); n_busy += int'(busy); end
        n_vec++; if (n_done != 0 || n_busy != 0) begin
            n_err++; $display("FAIL steady: dones=%0d busy_cycles=%0d want 0/0", n_done, n_busy);
        end
    endtask

    initial begin
        test_reset();
        test_value_change();
        test_wide();
        test_boundaries();
        test_midflight();
        test_reset_midflight();
        test_start_static();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
